// File: rtl/iomem_timer.sv
// iomem_timer: iomem-bus down-counting timer with prescaler, auto-reload and level interrupt.
// One wait state per access; window decoded on addr[31:8].
module iomem_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        irq_out
);
  logic        en_q, en_d, auto_q, auto_d, irqen_q, irqen_d, expired_q, expired_d;
  logic [31:0] load_q, load_d, count_q, count_d, rdata_d, rd_v;
  logic [15:0] prescale_q, prescale_d, pcnt_q, pcnt_d;
  logic        sel, wr, tick;
  logic [5:0]  off;
  logic        unused_ok;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8+:8] = s[i] ? nw[i*8+:8] : old[i*8+:8];
    return r;
  endfunction

  assign unused_ok = ^iomem_addr[1:0];
  // Gating on !iomem_ready keeps the ack to a single cycle while valid is still held.
  assign sel  = iomem_valid && iomem_addr[31:8] == BASE_ADDR[31:8] && !iomem_ready;
  assign wr   = sel && |iomem_wstrb;
  assign off  = iomem_addr[7:2];
  assign tick = en_q && pcnt_q == prescale_q;
  assign rd_v = off == 6'd0 ? {29'b0, irqen_q, auto_q, en_q} :
                off == 6'd1 ? load_q :
                off == 6'd2 ? count_q :
                off == 6'd3 ? {16'b0, prescale_q} :
                off == 6'd4 ? {31'b0, expired_q} : 32'b0;
  assign rdata_d = sel ? rd_v : 32'b0;
  assign irq_out = expired_q && irqen_q;

  always_comb begin
    en_d       = en_q;
    auto_d     = auto_q;
    irqen_d    = irqen_q;
    load_d     = load_q;
    count_d    = count_q;
    prescale_d = prescale_q;
    pcnt_d     = (!en_q || tick) ? 16'd0 : pcnt_q + 16'd1;
    if (tick) begin
      if (count_q != 32'd0) count_d = count_q - 32'd1;
      else if (auto_q) count_d = load_q;
      else en_d = 1'b0;
    end
    // Expiry beats a same-edge STATUS clear.
    expired_d = (tick && count_q == 32'd1) ? 1'b1 :
                (wr && off == 6'd4 && iomem_wstrb[0] && iomem_wdata[0]) ? 1'b0 : expired_q;
    if (wr && off == 6'd0 && iomem_wstrb[0]) {irqen_d, auto_d, en_d} = iomem_wdata[2:0];
    if (wr && off == 6'd1) load_d = merge(load_q, iomem_wdata, iomem_wstrb);
    if (wr && off == 6'd2) count_d = merge(count_q, iomem_wdata, iomem_wstrb);
    if (wr && off == 6'd3) begin
      prescale_d = {iomem_wstrb[1] ? iomem_wdata[15:8] : prescale_q[15:8],
                    iomem_wstrb[0] ? iomem_wdata[7:0]  : prescale_q[7:0]};
      pcnt_d     = 16'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      en_q        <= 1'b0;
      auto_q      <= 1'b0;
      irqen_q     <= 1'b0;
      expired_q   <= 1'b0;
      load_q      <= 32'd0;
      count_q     <= 32'd0;
      prescale_q  <= 16'd0;
      pcnt_q      <= 16'd0;
      iomem_ready <= 1'b0;
      iomem_rdata <= 32'd0;
    end else begin
      en_q        <= en_d;
      auto_q      <= auto_d;
      irqen_q     <= irqen_d;
      expired_q   <= expired_d;
      load_q      <= load_d;
      count_q     <= count_d;
      prescale_q  <= prescale_d;
      pcnt_q      <= pcnt_d;
      iomem_ready <= sel;
      iomem_rdata <= rdata_d;
    end
  end
endmodule

// File: tb/tb_iomem_timer.sv
// tb_iomem_timer: scoreboard bench; stimulus queues expected read data, a negedge monitor checks acks.
module tb_iomem_timer;
  localparam logic [31:0] B = 32'h0300_0000;
  logic        clk = 1'b0, resetn = 1'b0, iomem_valid = 1'b0, iomem_ready, irq_out;
  logic [3:0]  iomem_wstrb = 4'h0;
  logic [31:0] iomem_addr = 32'h0, iomem_wdata = 32'h0, iomem_rdata;
  int vectors = 0, miscompares = 0;

  typedef struct packed {logic rd; logic [31:0] a; logic [31:0] d;} exp_t;
  exp_t q[$];

  iomem_timer #(.BASE_ADDR(B)) dut (
    .clk(clk), .resetn(resetn), .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
    .iomem_rdata(iomem_rdata), .irq_out(irq_out)
  );

  always #5 clk = ~clk;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (iomem_ready) begin
      if (q.size() == 0) check("spurious_ready", {31'b0, iomem_ready}, 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        if (e.rd) check($sformatf("read_%h", e.a), iomem_rdata, e.d);
      end
    end
  end

  task automatic xfer(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                      input logic [31:0] exp, input bit hold);
    int n;
    @(negedge clk);
    q.push_back(exp_t'{s == 4'h0, a, exp});
    iomem_valid = 1'b1; iomem_addr = a; iomem_wstrb = s; iomem_wdata = d;
    n = 0;
    do begin @(negedge clk); n++; end while (!iomem_ready && n < 8);
    check("ack_latency", n, 1);
    if (hold) begin
      @(negedge clk);
      check("no_double_ack", {31'b0, iomem_ready}, 32'd0);
    end
    iomem_valid = 1'b0; iomem_wstrb = 4'h0;
  endtask

  task automatic wr(input logic [7:0] o, input logic [31:0] d);
    xfer(B + {24'b0, o}, 4'hF, d, 32'h0, 1'b0);
  endtask

  task automatic rd(input logic [7:0] o, input logic [31:0] exp);
    xfer(B + {24'b0, o}, 4'h0, 32'h0, exp, 1'b0);
  endtask

  task automatic irq_is(input string nm, input logic v);
    check(nm, {31'b0, irq_out}, {31'b0, v});
  endtask

  task automatic read_all_zero();
    for (int i = 0; i < 8; i++) rd(8'(i * 4), 32'h0);
    rd(8'hFC, 32'h0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    irq_is("reset_irq", 1'b0);
    check("reset_ready", {31'b0, iomem_ready}, 32'd0);
    read_all_zero();
    @(negedge clk);
    iomem_valid = 1'b1; iomem_addr = 32'h0200_0004; iomem_wstrb = 4'h0;
    repeat (4) begin @(negedge clk); check("outside_no_ack", {31'b0, iomem_ready}, 32'd0); end
    iomem_valid = 1'b0;
    // byte lanes
    xfer(B + 32'h4, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b1);
    xfer(B + 32'h4, 4'b0101, 32'h1234_5678, 32'h0, 1'b0);
    rd(8'h04, 32'hFF34_FF78);
    wr(8'h20, 32'hDEAD_BEEF);
    rd(8'h20, 32'h0);
    // one-shot: expiry on the third edge after the CTRL write
    wr(8'h0C, 32'h0);
    wr(8'h08, 32'd3);
    wr(8'h00, 32'h5);
    repeat (2) @(negedge clk);
    irq_is("oneshot_irq_before", 1'b0);
    @(negedge clk);
    irq_is("oneshot_irq_at", 1'b1);
    rd(8'h08, 32'h0);
    rd(8'h00, 32'h4);
    rd(8'h10, 32'h1);
    wr(8'h10, 32'h1);
    irq_is("oneshot_irq_cleared", 1'b0);
    rd(8'h10, 32'h0);
    // auto-reload, prescale 1: expiries at E+4, E+10, E+16
    wr(8'h0C, 32'h1);
    wr(8'h04, 32'd2);
    wr(8'h08, 32'd2);
    wr(8'h00, 32'h7);
    repeat (3) @(negedge clk);
    irq_is("auto1_before", 1'b0);
    @(negedge clk);
    irq_is("auto1_at", 1'b1);
    wr(8'h10, 32'h1);
    irq_is("auto1_cleared", 1'b0);
    repeat (3) @(negedge clk);
    irq_is("auto2_before", 1'b0);
    @(negedge clk);
    irq_is("auto2_at", 1'b1);
    wr(8'h10, 32'h1);
    irq_is("auto2_cleared", 1'b0);
    repeat (3) @(negedge clk);
    irq_is("auto3_before", 1'b0);
    @(negedge clk);
    irq_is("auto3_at", 1'b1);
    // collisions: clear at E+18, COUNT write on tick E+20, read at E+22
    wr(8'h10, 32'h1);
    wr(8'h08, 32'h50);
    rd(8'h08, 32'h50);
    // COUNT=2 on tick E+24, expiry at E+28 collides with STATUS clear
    wr(8'h08, 32'd2);
    repeat (2) @(negedge clk);
    wr(8'h10, 32'h1);
    rd(8'h10, 32'h1);
    irq_is("collision_irq", 1'b1);
    // reset mid-count with a pending read
    wr(8'h08, 32'd100);
    @(negedge clk);
    resetn = 1'b0; iomem_valid = 1'b1; iomem_addr = B + 32'h8; iomem_wstrb = 4'h0;
    @(negedge clk);
    resetn = 1'b1; iomem_valid = 1'b0;
    irq_is("midreset_irq", 1'b0);
    repeat (3) begin @(negedge clk); check("midreset_no_ack", {31'b0, iomem_ready}, 32'd0); end
    read_all_zero();
    irq_is("midreset_irq_after", 1'b0);
    repeat (2) @(negedge clk);
    check("queue_drained", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
